// File: rtl/ascon_block_packer_if.sv
// Word-in / block-out handshake bundle for the ASCON-AEAD128 block packer.
// msg_bytes_o exists only when ASCON_PACK_BYTECOUNT_EN is defined.
interface ascon_block_packer_if;
    logic [31:0]  word_i;
    logic         word_valid_i;
    logic         word_last_i;
    logic [2:0]   word_bytes_i;
    logic         word_ready_o;
    logic [127:0] block_o;
    logic         block_valid_o;
    logic         block_last_o;
    logic         block_ready_i;
`ifdef ASCON_PACK_BYTECOUNT_EN
    logic [31:0]  msg_bytes_o;

    modport master (
        output word_i, word_valid_i, word_last_i, word_bytes_i, block_ready_i,
        input  word_ready_o, block_o, block_valid_o, block_last_o, msg_bytes_o
    );
    modport slave (
        input  word_i, word_valid_i, word_last_i, word_bytes_i, block_ready_i,
        output word_ready_o, block_o, block_valid_o, block_last_o, msg_bytes_o
    );
`else
    modport master (
        output word_i, word_valid_i, word_last_i, word_bytes_i, block_ready_i,
        input  word_ready_o, block_o, block_valid_o, block_last_o
    );
    modport slave (
        input  word_i, word_valid_i, word_last_i, word_bytes_i, block_ready_i,
        output word_ready_o, block_o, block_valid_o, block_last_o
    );
`endif
endinterface

// File: rtl/ascon_block_packer.sv
// Packs a 32-bit word stream into padded little-endian 128-bit ASCON-AEAD128 rate blocks.
// Optional running byte counter (msg_bytes_o) enabled by defining ASCON_PACK_BYTECOUNT_EN.
module ascon_block_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h01
) (
    input  logic clock_i,
    input  logic rst_i,
    ascon_block_packer_if.slave bus
);
    typedef enum logic [1:0] {FILL, FULL, FULL_PADNEXT, PADBLK} state_t;

    state_t       state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [127:0] blk_q, blk_d;
    logic         last_q, last_d;

    logic [2:0]   nb;
    logic [4:0]   pos;
    logic [127:0] blk_fill;
    logic         word_fire;
    logic         block_fire;

    // Non-last words always carry four bytes; out-of-range counts saturate at four.
    assign nb  = (!bus.word_last_i || bus.word_bytes_i > 3'd4) ? 3'd4 : bus.word_bytes_i;
    assign pos = {1'b0, idx_q, 2'b00} + {2'b00, nb};

    assign word_fire  = (state_q == FILL) && bus.word_valid_i;
    assign block_fire = (state_q != FILL) && bus.block_ready_i;

    // Bytes above the current word are always zero here, so only the word
    // slot and the pad position need rewriting.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam logic [1:0] WSEL = 2'(gi / 4);
        localparam int         J    = gi % 4;
        localparam logic [4:0] K    = 5'(gi);
        assign blk_fill[8*gi +: 8] =
            (WSEL == idx_q && 3'(J) < nb)       ? bus.word_i[8*J +: 8] :
            (bus.word_last_i && K == pos)       ? PAD_BYTE :
                                                  blk_q[8*gi +: 8];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        blk_d   = blk_q;
        last_d  = last_q;
        case (state_q)
            FILL: begin
                if (bus.word_valid_i) begin
                    blk_d = blk_fill;
                    idx_d = idx_q + 2'd1;
                    if (bus.word_last_i) begin
                        if (pos == 5'd16) begin
                            state_d = FULL_PADNEXT;
                            last_d  = 1'b0;
                        end else begin
                            state_d = FULL;
                            last_d  = 1'b1;
                        end
                    end else if (idx_q == 2'd3) begin
                        state_d = FULL;
                        last_d  = 1'b0;
                    end
                end
            end
            FULL: begin
                if (bus.block_ready_i) begin
                    state_d = FILL;
                    idx_d   = 2'd0;
                    blk_d   = '0;
                    last_d  = 1'b0;
                end
            end
            FULL_PADNEXT: begin
                if (bus.block_ready_i) begin
                    state_d = PADBLK;
                    idx_d   = 2'd0;
                    blk_d   = '0;
                    last_d  = 1'b1;
                end
            end
            PADBLK: begin
                if (bus.block_ready_i) begin
                    state_d = FILL;
                    idx_d   = 2'd0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = 2'd0;
                blk_d   = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
            idx_q   <= 2'd0;
            blk_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
        end
    end

    assign bus.word_ready_o  = (state_q == FILL);
    assign bus.block_valid_o = (state_q != FILL);
    assign bus.block_last_o  = last_q;
    assign bus.block_o       = (state_q == PADBLK) ? {120'b0, PAD_BYTE} : blk_q;

`ifdef ASCON_PACK_BYTECOUNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (word_fire) begin
            cnt_d = cnt_q + 32'(nb);
        end else if (block_fire && last_q) begin
            cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clock_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.msg_bytes_o = cnt_q;
`endif
endmodule

// File: tb/tb_ascon_block_packer.sv
// Scoreboard bench for ascon_block_packer: stimulus pushes expected blocks, a negedge monitor pops and compares.
module tb_ascon_block_packer;
    logic clock_i = 1'b0;
    logic rst_i;
    always #5 clock_i = ~clock_i;

    ascon_block_packer_if bus();

    ascon_block_packer dut (
        .clock_i (clock_i),
        .rst_i   (rst_i),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [128:0] exp_q[$];
    logic [128:0] mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_block(input logic [127:0] blk, input logic last);
        exp_q.push_back({last, blk});
    endtask

    // Monitor: every observed block transfer is matched against the scoreboard head.
    always @(negedge clock_i) begin
        if (rst_i === 1'b0 && bus.block_valid_o === 1'b1 && bus.block_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_block actual=%h required=none", bus.block_o);
            end else begin
                mon_e = exp_q.pop_front();
                $display("block %h last=%0b", bus.block_o, bus.block_last_o);
                check("block_data", bus.block_o, mon_e[127:0]);
                check("block_last", {127'b0, bus.block_last_o}, {127'b0, mon_e[128]});
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input logic last, input logic [2:0] nbytes);
        int n;
        @(negedge clock_i);
        bus.word_i       = w;
        bus.word_valid_i = 1'b1;
        bus.word_last_i  = last;
        bus.word_bytes_i = nbytes;
        n = 0;
        while (bus.word_ready_o !== 1'b1 && n < 100) begin
            @(negedge clock_i);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL word_ready_timeout actual=0 required=1");
        end
        @(posedge clock_i);
    endtask

    task automatic idle();
        @(negedge clock_i);
        bus.word_valid_i = 1'b0;
        bus.word_last_i  = 1'b0;
        bus.word_bytes_i = 3'd0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock_i);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
    endtask

    initial begin
        rst_i             = 1'b1;
        bus.word_i        = 32'h0;
        bus.word_valid_i  = 1'b0;
        bus.word_last_i   = 1'b0;
        bus.word_bytes_i  = 3'd0;
        bus.block_ready_i = 1'b1;
        repeat (2) @(negedge clock_i);
        check("reset_block_o", bus.block_o, 128'h0);
        check("reset_block_valid", {127'b0, bus.block_valid_o}, 128'h0);
        check("reset_block_last", {127'b0, bus.block_last_o}, 128'h0);
        check("reset_word_ready", {127'b0, bus.word_ready_o}, 128'h1);
`ifdef ASCON_PACK_BYTECOUNT_EN
        check("reset_msg_bytes", {96'b0, bus.msg_bytes_o}, 128'h0);
`endif
        rst_i = 1'b0;

        // 8 full words, last full -> two data blocks and a pad-only block
        expect_block(128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0);
        expect_block(128'h1F1E1D1C_1B1A1918_17161514_13121110, 1'b0);
        expect_block(128'h00000000_00000000_00000000_00000001, 1'b1);
        for (int i = 0; i < 8; i++)
            send_word(32'h03020100 + 32'(i) * 32'h04040404, i == 7, 3'd4);
        idle();
        drain();

        // 3 words, last has 2 bytes -> pad at byte 10
        expect_block(128'h00000000_0001BBAA_07060504_03020100, 1'b1);
        send_word(32'h03020100, 1'b0, 3'd4);
        send_word(32'h07060504, 1'b0, 3'd4);
        send_word(32'hDDCCBBAA, 1'b1, 3'd2);
        idle();
        drain();

        // empty message
        expect_block(128'h1, 1'b1);
        send_word(32'hFFFFFFFF, 1'b1, 3'd0);
        idle();
        drain();

        // 4 words, last has 3 bytes -> pad lands on byte 15, byte 0x0F discarded
        expect_block(128'h010E0D0C_0B0A0908_07060504_03020100, 1'b1);
        for (int i = 0; i < 4; i++)
            send_word(32'h03020100 + 32'(i) * 32'h04040404, i == 3, 3'd3);
        idle();
        drain();

        // 2 words, last full -> pad at byte 8
        expect_block(128'h00000000_00000001_07060504_03020100, 1'b1);
        send_word(32'h03020100, 1'b0, 3'd4);
        send_word(32'h07060504, 1'b1, 3'd4);
        idle();
        drain();

        // backpressure: FULL block held 10 cycles while a word waits
        @(negedge clock_i);
        bus.block_ready_i = 1'b0;
        expect_block(128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0, 1'b0);
        expect_block(128'h00000000_00000000_00000001_55443322, 1'b1);
        for (int i = 0; i < 4; i++)
            send_word(32'hA3A2A1A0 + 32'(i) * 32'h04040404, 1'b0, 3'd4);
        @(negedge clock_i);
        bus.word_i       = 32'h55443322;
        bus.word_valid_i = 1'b1;
        bus.word_last_i  = 1'b1;
        bus.word_bytes_i = 3'd4;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock_i);
            check("hold_block_o", bus.block_o, 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0);
            check("hold_block_valid", {127'b0, bus.block_valid_o}, 128'h1);
            check("hold_block_last", {127'b0, bus.block_last_o}, 128'h0);
            check("hold_word_ready", {127'b0, bus.word_ready_o}, 128'h0);
        end
        bus.block_ready_i = 1'b1;
        send_word(32'h55443322, 1'b1, 3'd4);
        idle();
        drain();

        // reset after 2 words; only post-reset words appear
        send_word(32'h11111111, 1'b0, 3'd4);
        send_word(32'h22222222, 1'b0, 3'd4);
        idle();
        rst_i = 1'b1;
        @(negedge clock_i);
        check("midrst_word_ready", {127'b0, bus.word_ready_o}, 128'h1);
        check("midrst_block_valid", {127'b0, bus.block_valid_o}, 128'h0);
        rst_i = 1'b0;
        expect_block(128'hCFCECDCC_CBCAC9C8_C7C6C5C4_C3C2C1C0, 1'b0);
        expect_block(128'h00000000_00000000_00000000_00000001, 1'b1);
        for (int i = 0; i < 4; i++)
            send_word(32'hC3C2C1C0 + 32'(i) * 32'h04040404, i == 3, 3'd4);
        idle();
        drain();

`ifdef ASCON_PACK_BYTECOUNT_EN
        // 21-byte message: count reaches 21, clears after the final block
        expect_block(128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0);
        expect_block(128'h00000000_00000000_00000114_13121110, 1'b1);
        for (int i = 0; i < 5; i++)
            send_word(32'h03020100 + 32'(i) * 32'h04040404, 1'b0, 3'd4);
        @(negedge clock_i);
        bus.block_ready_i = 1'b0;
        send_word(32'h17161514, 1'b1, 3'd1);
        idle();
        check("msg_bytes_21", {96'b0, bus.msg_bytes_o}, 128'd21);
        bus.block_ready_i = 1'b1;
        drain();
        @(negedge clock_i);
        check("msg_bytes_cleared", {96'b0, bus.msg_bytes_o}, 128'd0);
`endif

        repeat (3) @(negedge clock_i);
        check("no_extra_valid", {127'b0, bus.block_valid_o}, 128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ascon_block_packer.md
Name: ascon_block_packer

Overview:
- Upstream feeder for the ASCON-AEAD128 top.
- Accepts a 32-bit word stream from the host bus and assembles 128-bit rate blocks, little-endian.
- Applies ASCON-AEAD128 padding: a 0x01 byte follows the last data byte, then zeros. A full trailing block forces an extra pad-only block.
- Presents each block with a valid/ready handshake; the core's data_valid_i / data_i are driven from block_valid_o / block_o.

Parameters:
- PAD_BYTE, 8'h01, padding byte inserted after the last data byte.

Ports:
- clock_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- word_i  in  32  input word; byte j at bits [8j+7:8j].
- word_valid_i  in  1  word_i is valid.
- word_last_i  in  1  word is the final word of the message.
- word_bytes_i  in  3  valid byte count of a last word, 0..4. Ignored (treated as 4) when word_last_i=0.
- word_ready_o  out  1  packer accepts a word this cycle.
- block_o  out  128  assembled block; block byte k at bits [8k+7:8k].
- block_valid_o  out  1  block_o is valid.
- block_last_o  out  1  block is the final (padded) block of the message.
- block_ready_i  in  1  consumer accepts the block.

Behaviour:
- Reset: asynchronous, active-high on rst_i. All state cleared.
  - Outputs at reset: block_o=0, block_valid_o=0, block_last_o=0, word_ready_o=1 (FILL state, word index 0).
- Word transfer: happens on a rising edge with word_valid_i & word_ready_o. Block transfer: happens with block_valid_o & block_ready_i.
- Word placement: word n (0..3) fills block bytes 4n..4n+3. The 2-bit word index increments per accepted word and wraps 3->0.
- States:
  - FILL: word_ready_o=1, block_valid_o=0.
    - 4th non-last word accepted -> FULL, block_last_o=0.
    - Last word with total byte position p = 4n + word_bytes_i:
      - p < 16: byte p = PAD_BYTE, bytes p+1..15 = 0, block_last_o=1 -> FULL.
      - p = 16: block_last_o=0 -> FULL_PADNEXT.
  - FULL: block_valid_o=1, word_ready_o=0.
    - On block transfer -> FILL, index=0, block register cleared.
  - FULL_PADNEXT: block_valid_o=1, block_last_o=0, word_ready_o=0.
    - On block transfer -> PADBLK.
  - PADBLK: block_o = {120'b0, PAD_BYTE}, block_valid_o=1, block_last_o=1, word_ready_o=0.
    - On block transfer -> FILL.
- Latency: block_valid_o rises the cycle after the accepting edge of the completing word. Throughput is one block per 5 cycles with block_ready_i held high.
- Stability: while block_valid_o=1 and block_ready_i=0, block_o and block_last_o hold stable. Valid never drops without a transfer.
- Empty message: a last word with word_bytes_i=0 at index 0 yields the single block 128'h...01 with block_last_o=1.
- Data bytes beyond word_bytes_i in a last word are discarded (replaced by pad/zero).
- Word arrivals with word_ready_o=0 are not accepted. The host must hold the word until ready.
- Reset mid-message: the partial block is discarded and the next accepted word starts a new block at index 0.

Optional Feature:
- Macro ASCON_PACK_BYTECOUNT_EN.
- Defined:
  - Adds output msg_bytes_o [31:0]: running count of data bytes accepted in the current message (pad bytes excluded). Width is 32 bits and wraps modulo 2^32.
  - The count updates on each word transfer.
  - It clears to 0 on the block transfer of the final block and on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- 8 words 0x03020100,0x07060504,...,0x1F1E1D1C, last on word 8 with bytes=4, block_ready_i=1 -> blocks 0x0F0E..0100 (last=0), 0x1F1E..1110 (last=0), then 0x...0001 (last=1).
- 3 words, last word 0xDDCCBBAA with bytes=2 -> one block, bytes 0..9 data, byte 10=0x01, bytes 11..15=0, last=1.
- Empty message: single word, last=1, bytes=0 -> block_o=128'h1, block_last_o=1.
- Hold block_ready_i=0 for 10 cycles on a FULL block -> block_o stable, word_ready_o=0, and no words are consumed while word_valid_i stays high.
- Assert rst_i after 2 words of a block, then send 4 words -> the emitted block contains only the post-reset words.
- With ASCON_PACK_BYTECOUNT_EN: a 21-byte message -> msg_bytes_o reaches 21, then reads 0 after the final block transfer.
